// File: rtl/div4b_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and default operand width.
package div4b_pkg;

  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div4b_subnb.sv
// W-bit ripple-borrow subtractor (diff = a - b), built from 1-bit full subtractors.
// Purely combinational; borrow is set when b > a.
module subnb #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0] bc;

  assign bc[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < W; i++) begin : g_fs
      assign diff[i]  = a[i] ^ b[i] ^ bc[i];
      assign bc[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bc[i]);
    end
  endgenerate

  assign borrow = bc[W];

endmodule

// File: rtl/div4b.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Done N+1 cycles after an accepted start (1 for divide-by-zero); start is ignored while busy.
module div4b
  import div4b_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  state_t         state, state_nxt;
  logic [N:0]     r, r_sh, r_nxt, t;
  logic [N-1:0]   q, q_sh, d;
  logic [CW-1:0]  cnt;
  logic           borrow;
  logic           accept;
  logic           last;
  logic           unused_r_msb;

  // R[N] is always 0 after a restore step, so it never reaches the shifted value.
  assign unused_r_msb = r[N];

  assign r_sh  = {r[N-1:0], q[N-1]};
  assign q_sh  = {q[N-2:0], ~borrow};
  assign r_nxt = borrow ? r_sh : t;

  subnb #(
    .W(N + 1)
  ) u_sub (
    .a     (r_sh),
    .b     ({1'b0, d}),
    .diff  (t),
    .borrow(borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (divisor == '0) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        busy = 1'b1;
        if (cnt == CW'(1)) begin
          last      = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Results are loaded on the edge into DONE so they are valid during the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      div_by_zero <= (divisor == '0);
      if (divisor == '0) begin
        quotient  <= '1;
        remainder <= dividend;
      end else begin
        d   <= divisor;
        r   <= '0;
        q   <= dividend;
        cnt <= CW'(N);
      end
    end else if (state == ST_CALC) begin
      r   <= r_nxt;
      q   <= q_sh;
      cnt <= cnt - 1'b1;
      if (last) begin
        quotient  <= q_sh;
        remainder <= r_nxt[N-1:0];
      end
    end
  end

endmodule

// File: tb/tb_div4b.sv
// Scoreboard bench for div4b: stimulus pushes expected results, a negedge monitor pops on done.
module tb_div4b;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];

  div4b #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 (q=%0d r=%0d dz=%0d), expected none",
                 quotient, remainder, div_by_zero);
      end else begin
        e = sb.pop_front();
        chk("result_q", 32'(quotient), 32'(e.q));
        chk("result_r", 32'(remainder), 32'(e.r));
        chk("result_dz", 32'(div_by_zero), 32'(e.dz));
      end
    end
  end

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input bit push, input exp_t e);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic run(input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic [N-1:0] eq, input logic [N-1:0] er, input logic edz);
    exp_t e;
    int   lat;
    e = '{q: eq, r: er, dz: edz};
    issue(a, b, 1'b1, e);
    wait_done(lat);
    chk("latency", 32'(lat), edz ? 32'd0 : 32'(N));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [N-1:0] ta[4];
    logic [N-1:0] tb[4];
    logic [N-1:0] tq[4];
    logic [N-1:0] tr[4];
    int lat;
    exp_t e;

    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 13/3 and divide-by-zero
    run(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    run(4'd7, 4'd0, 4'd15, 4'd7, 1'b1);
    @(negedge clk);
    chk("dz_busy_after", 32'(busy), 32'd0);

    // Edge values
    ta = '{4'd3, 4'd15, 4'd15, 4'd0};
    tb = '{4'd9, 4'd15, 4'd1, 4'd5};
    tq = '{4'd0, 4'd1, 4'd15, 4'd0};
    tr = '{4'd3, 4'd0, 4'd0, 4'd0};
    for (int k = 0; k < 4; k++) run(ta[k], tb[k], tq[k], tr[k], 1'b0);

    // Starts while busy (mid-CALC and in DONE) are ignored
    e = '{q: 4'd4, r: 4'd1, dz: 1'b0};
    issue(4'd13, 4'd3, 1'b1, e);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      start = (i == 1);
      if (i == 1) begin
        dividend = 4'd9;
        divisor  = 4'd2;
        chk("busy_mid_calc", 32'(busy), 32'd1);
      end
    end
    chk("busy_latency", 32'(lat), 32'(N));
    start    = 1'b1;
    dividend = 4'd6;
    divisor  = 4'd0;
    @(negedge clk);
    start = 1'b0;
    chk("hold_busy", 32'(busy), 32'd0);
    chk("hold_q", 32'(quotient), 32'd4);
    chk("hold_r", 32'(remainder), 32'd1);
    chk("hold_dz", 32'(div_by_zero), 32'd0);
    repeat (3) @(negedge clk);
    chk("hold_q_later", 32'(quotient), 32'd4);
    chk("hold_r_later", 32'(remainder), 32'd1);
    chk("hold_done_low", 32'(done), 32'd0);

    // Reset two cycles into CALC
    issue(4'd13, 4'd3, 1'b0, e);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_q", 32'(quotient), 32'd0);
    chk("arst_r", 32'(remainder), 32'd0);
    chk("arst_dz", 32'(div_by_zero), 32'd0);
    repeat (6) @(negedge clk);
    rst_n = 1'b1;
    run(4'd14, 4'd4, 4'd3, 4'd2, 1'b0);

    // Exhaustive sweep against / and %
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) run(N'(a), N'(b), 4'd15, N'(a), 1'b1);
        else        run(N'(a), N'(b), N'(a / b), N'(a % b), 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
